cfg_lock_programmer: RTL and testbench

Boot-time initiator for lockable 16-bit configuration registers. It accepts a stream of configuration values, writes each value into the register at that position in the bank and verifies it by readback. It then asserts the per-register lock. Optionally it proves each lock holds by attempting a forbidden write. It sits between the secure-boot configuration source and the lockable register bank, and drives that bank's write, lock and data inputs.

---
 rtl/cfg_lock_pkg.sv | 23 ++
 rtl/cfg_lock_programmer.sv | 155 +++++++++++++++
 tb/tb_cfg_lock_programmer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_lock_pkg.sv
// Shared types and constants for cfg_lock_programmer.
package cfg_lock_pkg;

    localparam int CFG_DW_DEFAULT = 16;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_VERIFY = 2'd1;
    localparam logic [1:0] ERR_PROBE  = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WRITE,
        CHECK,
        LOCK,
        PREAD,
        PWRITE,
        PCHECK,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/cfg_lock_programmer.sv
// Boot-time programmer: write, verify, then lock each register of a lockable bank.
// Define CFG_LOCK_PROBE_EN to add a per-register lock probe (forbidden write + readback).
module cfg_lock_programmer
    import cfg_lock_pkg::*;
#(
    parameter int DW       = CFG_DW_DEFAULT,
    parameter int NUM_REGS = 4,
    parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_data,
    output logic [AW-1:0] reg_addr,
    output logic [DW-1:0] reg_wdata,
    output logic          reg_write,
    output logic          reg_lock,
    input  logic [DW-1:0] reg_rdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [AW-1:0] err_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] data_reg, data_next;
    logic [1:0]    err_code_reg, err_code_next;
    logic [AW-1:0] err_addr_reg, err_addr_next;
`ifdef CFG_LOCK_PROBE_EN
    logic [DW-1:0] shadow_reg, shadow_next;
`endif

    logic at_last;
    assign at_last = (addr_reg == LAST_ADDR);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            err_code_reg <= ERR_NONE;
            err_addr_reg <= '0;
`ifdef CFG_LOCK_PROBE_EN
            shadow_reg   <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            err_code_reg <= err_code_next;
            err_addr_reg <= err_addr_next;
`ifdef CFG_LOCK_PROBE_EN
            shadow_reg   <= shadow_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        err_code_next = err_code_reg;
        err_addr_next = err_addr_reg;
`ifdef CFG_LOCK_PROBE_EN
        shadow_next   = shadow_reg;
`endif
        case (state_reg)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next    = LOAD;
                    addr_next     = '0;
                    err_code_next = ERR_NONE;
                    err_addr_next = '0;
                end
            end
            LOAD: begin
                if (cfg_valid) begin
                    data_next  = cfg_data;
                    state_next = WRITE;
                end
            end
            WRITE: state_next = CHECK;
            CHECK: begin
                if (reg_rdata != data_reg) begin
                    state_next    = ERROR;
                    err_code_next = ERR_VERIFY;
                    err_addr_next = addr_reg;
                end else if (at_last) begin
                    state_next = LOCK;
                    addr_next  = '0;
                end else begin
                    state_next = LOAD;
                    addr_next  = addr_reg + AW'(1);
                end
            end
            LOCK: begin
                if (at_last) begin
`ifdef CFG_LOCK_PROBE_EN
                    state_next = PREAD;
                    addr_next  = '0;
`else
                    state_next = DONE;
`endif
                end else begin
                    addr_next = addr_reg + AW'(1);
                end
            end
`ifdef CFG_LOCK_PROBE_EN
            PREAD: begin
                shadow_next = reg_rdata;
                state_next  = PWRITE;
            end
            PWRITE: state_next = PCHECK;
            // Any change after the inverted write means the lock was bypassed.
            PCHECK: begin
                if (reg_rdata != shadow_reg) begin
                    state_next    = ERROR;
                    err_code_next = ERR_PROBE;
                    err_addr_next = addr_reg;
                end else if (at_last) begin
                    state_next = DONE;
                end else begin
                    state_next = PREAD;
                    addr_next  = addr_reg + AW'(1);
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign cfg_ready = (state_reg == LOAD);
    assign reg_lock  = (state_reg == LOCK);
    assign busy      = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERROR);
    assign done      = (state_reg == DONE);
    assign error     = (state_reg == ERROR);
    assign reg_addr  = addr_reg;
    assign err_code  = err_code_reg;
    assign err_addr  = err_addr_reg;

`ifdef CFG_LOCK_PROBE_EN
    assign reg_write = (state_reg == WRITE) || (state_reg == PWRITE);
    assign reg_wdata = (state_reg == PWRITE) ? ~shadow_reg : data_reg;
`else
    assign reg_write = (state_reg == WRITE);
    assign reg_wdata = data_reg;
`endif

endmodule

// File: tb/tb_cfg_lock_programmer.sv
// Scoreboard bench for cfg_lock_programmer with a lockable register bank model.
`timescale 1ns/1ps
module tb_cfg_lock_programmer;

    localparam int DW       = 16;
    localparam int NUM_REGS = 4;
    localparam int AW       = 2;
`ifdef CFG_LOCK_PROBE_EN
    localparam bit PROBE = 1'b1;
`else
    localparam bit PROBE = 1'b0;
`endif

    logic          Clk;
    logic          reset;
    logic          start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_write;
    logic          reg_lock;
    logic [DW-1:0] reg_rdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;

    cfg_lock_programmer #(.DW(DW), .NUM_REGS(NUM_REGS)) dut (
        .Clk(Clk), .reset(reset), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
        .reg_lock(reg_lock), .reg_rdata(reg_rdata),
        .busy(busy), .done(done), .error(error),
        .err_code(err_code), .err_addr(err_addr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- lockable register bank (environment) ----------------
    logic [DW-1:0] bank   [NUM_REGS];
    logic          locked [NUM_REGS];
    logic scan_mode, debug_override, stuck_en, bank_clr;

    assign reg_rdata = bank[reg_addr];

    always @(posedge Clk) begin
        if (bank_clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i]   <= '0;
                locked[i] <= 1'b0;
            end
        end else begin
            if (reg_write && (!locked[reg_addr] || scan_mode || debug_override))
                bank[reg_addr] <= (stuck_en && reg_addr == AW'(2)) ? (reg_wdata & 16'hFFFE) : reg_wdata;
            if (reg_lock)
                locked[reg_addr] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic d; logic e; logic [1:0] code; logic [AW-1:0] addr; int cyc; } end_t;

    wr_t           exp_wr   [$];
    logic [AW-1:0] exp_lock [$];
    end_t          exp_end  [$];

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endfunction

    logic done_q = 1'b0;
    logic error_q = 1'b0;

    always @(negedge Clk) begin
        if (!reset) begin
            if (reg_write && reg_lock) check("strobe_overlap", 32'd1, 32'd0);
            if (reg_write) begin
                if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("write_addr", 32'(reg_addr), 32'(w.addr));
                    check("write_data", 32'(reg_wdata), 32'(w.data));
                    $display("write addr=%0d data=%04h", reg_addr, reg_wdata);
                end
            end
            if (reg_lock) begin
                if (exp_lock.size() == 0) check("unexpected_lock", 32'd1, 32'd0);
                else begin
                    logic [AW-1:0] la;
                    la = exp_lock.pop_front();
                    check("lock_addr", 32'(reg_addr), 32'(la));
                    $display("lock  addr=%0d", reg_addr);
                end
            end
            if ((done && !done_q) || (error && !error_q)) begin
                if (exp_end.size() == 0) check("unexpected_end", 32'd1, 32'd0);
                else begin
                    end_t e;
                    e = exp_end.pop_front();
                    check("end_done", 32'(done), 32'(e.d));
                    check("end_error", 32'(error), 32'(e.e));
                    check("end_code", 32'(err_code), 32'(e.code));
                    check("end_addr", 32'(err_addr), 32'(e.addr));
                    if (e.cyc >= 0) check("end_cycle", 32'(cyc), 32'(e.cyc));
                    $display("end   done=%0d error=%0d code=%0d addr=%0d cyc=%0d",
                             done, error, err_code, err_addr, cyc);
                end
            end
        end
        done_q  <= done;
        error_q <= error;
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] run_data [NUM_REGS];
    logic [DW-1:0] m_bank   [NUM_REGS];
    bit            m_lock   [NUM_REGS];

    function automatic logic [DW-1:0] stick(input int a, input logic [DW-1:0] v);
        return (stuck_en && a == 2) ? (v & 16'hFFFE) : v;
    endfunction

    task automatic clear_bank();
        bank_clr = 1'b1;
        @(posedge Clk);
        #1 bank_clr = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_bank[i] = '0;
            m_lock[i] = 1'b0;
        end
    endtask

    task automatic random_data();
        for (int i = 0; i < NUM_REGS; i++) run_data[i] = DW'($urandom);
    endtask

    task automatic run(input bit toggle, input int abort_at, input bit busy_pulse);
        logic [DW-1:0] feed [$];
        logic [DW-1:0] nv;
        end_t e;
        wr_t  w;
        int   fin, sc, t, accepted, exp_acc;
        bit   hs, bypass;

        // Expected behaviour derived from the programming rules
        bypass  = scan_mode || debug_override;
        e.d = 1'b1; e.e = 1'b0; e.code = 2'd0; e.addr = '0;
        fin = -1;
        exp_acc = NUM_REGS;
        for (int i = 0; i < NUM_REGS; i++) begin
            w.addr = AW'(i); w.data = run_data[i];
            exp_wr.push_back(w);
            if (!m_lock[i] || bypass) m_bank[i] = stick(i, run_data[i]);
            if (m_bank[i] != run_data[i]) begin
                e.d = 1'b0; e.e = 1'b1; e.code = 2'd1; e.addr = AW'(i);
                fin = 1 + 3 * (i + 1);
                exp_acc = i + 1;
                break;
            end
        end
        if (fin < 0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                exp_lock.push_back(AW'(i));
                m_lock[i] = 1'b1;
            end
            fin = 1 + 4 * NUM_REGS;
            if (PROBE) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    w.addr = AW'(i); w.data = ~m_bank[i];
                    exp_wr.push_back(w);
                    nv = bypass ? stick(i, ~m_bank[i]) : m_bank[i];
                    if (nv != m_bank[i]) begin
                        m_bank[i] = nv;
                        e.d = 1'b0; e.e = 1'b1; e.code = 2'd2; e.addr = AW'(i);
                        fin = 1 + 4 * NUM_REGS + 3 * (i + 1);
                        break;
                    end
                end
                if (e.d) fin = 1 + 7 * NUM_REGS;
            end
        end

        feed.delete();
        for (int i = 0; i < NUM_REGS; i++) feed.push_back(run_data[i]);

        @(posedge Clk);
        #1;
        sc = cyc;
        e.cyc = toggle ? -1 : sc + fin;
        exp_end.push_back(e);
        start = 1'b1;
        t = 0;
        accepted = 0;
        while (t < 400) begin
            cfg_valid = (feed.size() > 0) && (!toggle || (t % 2 == 0));
            cfg_data  = (feed.size() > 0) ? feed[0] : '0;
            @(negedge Clk);
            hs = cfg_valid && cfg_ready;
            @(posedge Clk);
            t++;
            if (hs) begin
                void'(feed.pop_front());
                accepted++;
            end
            #1;
            if (t == 1) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done_clear", 32'(done), 32'd0);
                check("run_error_clear", 32'(error), 32'd0);
            end
            if (abort_at > 0 && t == abort_at) begin
                #2 reset = 1'b1;
                #1 check("reset_outputs",
                         32'({cfg_ready, reg_write, reg_lock, busy, done, error,
                              reg_addr, reg_wdata, err_code, err_addr}), 32'd0);
                exp_wr.delete();
                exp_lock.delete();
                exp_end.delete();
                cfg_valid = 1'b0;
                start     = 1'b0;
                repeat (2) @(posedge Clk);
                @(negedge Clk);
                reset = 1'b0;
                return;
            end
            if (done || error) break;
            start = busy_pulse && (t == 4 || t == 10 || t == 21);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        check("run_finished", 32'(done || error), 32'd1);
        @(negedge Clk);
        #1;
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_locks", 32'(exp_lock.size()), 32'd0);
        check("pending_ends", 32'(exp_end.size()), 32'd0);
        check("accepted_count", 32'(accepted), 32'(exp_acc));
        if (e.d) begin
            for (int i = 0; i < NUM_REGS; i++) check("bank_contents", 32'(bank[i]), 32'(run_data[i]));
        end
        exp_wr.delete();
        exp_lock.delete();
        exp_end.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        scan_mode = 1'b0; debug_override = 1'b0; stuck_en = 1'b0; bank_clr = 1'b0;
        repeat (3) @(posedge Clk);
        #1 check("reset_state",
                 32'({cfg_ready, reg_write, reg_lock, busy, done, error,
                      reg_addr, reg_wdata, err_code, err_addr}), 32'd0);
        @(negedge Clk) reset = 1'b0;
        clear_bank();

        // clean run
        for (int i = 0; i < NUM_REGS; i++) run_data[i] = DW'(16'h1111 * (i + 1));
        run(1'b0, 0, 1'b0);

        // stuck bit at address 2
        clear_bank();
        stuck_en = 1'b1;
        run(1'b0, 0, 1'b0);
        stuck_en = 1'b0;

        // lock bypass through scan mode
        clear_bank();
        scan_mode = 1'b1;
        random_data();
        run(1'b0, 0, 1'b0);
        scan_mode = 1'b0;

        // backpressure on the config stream
        clear_bank();
        random_data();
        run(1'b1, 0, 1'b0);

        // reset mid-run, then a fresh run
        clear_bank();
        random_data();
        run(1'b0, 7, 1'b0);
        clear_bank();
        random_data();
        run(1'b0, 0, 1'b0);

        // start while busy is ignored; start in DONE reruns on the locked bank
        clear_bank();
        random_data();
        run(1'b0, 0, 1'b1);
        run(1'b0, 0, 1'b0);

        // random runs, some with debug override
        for (int k = 0; k < 4; k++) begin
            clear_bank();
            random_data();
            debug_override = 1'($urandom_range(0, 1));
            run(1'($urandom_range(0, 1)), 0, 1'b0);
            debug_override = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
